// File: rtl/regs_ctrl_pkg.sv
// Shared types and constants for the register-file
// write-port controller.
package regs_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [31:0]       data;
  } io_wr_t;

endpackage

// File: rtl/regs_io_fifo.sv
// Synchronous FIFO of queued I/O register writes.
// Head is read straight from storage.
module regs_io_fifo
  import regs_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  io_wr_t        push_d,
  input  logic          pop,
  output io_wr_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  io_wr_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= push_d;
  end

endmodule

// File: rtl/regs_port_ctrl.sv
// Arbitrates the register-file write port between WB,
// queued I/O writes and the register-clear sequence.
module regs_port_ctrl #(
  parameter int IO_DEPTH = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_write,
  input  logic [4:0]                wb_reg,
  input  logic [31:0]               wb_data,
  input  logic                      io_valid,
  output logic                      io_ready,
  input  logic [4:0]                io_reg,
  input  logic [31:0]               io_data,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      stall,
  output logic                      wb_drop,
  output logic [$clog2(IO_DEPTH):0] io_count,
  output logic                      write,
  output logic [4:0]                write_reg,
  output logic [31:0]               write_data
);
  import regs_ctrl_pkg::*;

  localparam logic [REG_AW-1:0] LAST =
    REG_AW'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic              drop_q, drop_d;
  logic              pop, full, empty, wb_hit;
  io_wr_t            head, push_d;

  assign push_d   = '{rd: io_reg, data: io_data};
  assign io_ready = !full;
  assign clr_busy = (state_q == ST_CLEAR);
  assign stall    = clr_busy;
  assign wb_drop  = drop_q;
  assign wb_hit   = wb_write && (wb_reg != REG_ZERO);

  regs_io_fifo #(.DEPTH(IO_DEPTH)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (io_valid && !full),
    .push_d (push_d),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (io_count)
  );

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    drop_d     = drop_q;
    pop        = 1'b0;
    clr_done   = 1'b0;
    write      = 1'b0;
    write_reg  = REG_ZERO;
    write_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_hit) begin
          write      = 1'b1;
          write_reg  = wb_reg;
          write_data = wb_data;
        end else if (!empty) begin
          // A zero-target head is consumed silently.
          pop        = 1'b1;
          write      = (head.rd != REG_ZERO);
          write_reg  = head.rd;
          write_data = head.data;
        end
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        write     = 1'b1;
        write_reg = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (wb_write) drop_d = 1'b1;
        if (clr_cnt_q == LAST) begin
          clr_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_regs_port_ctrl.sv
// Directed table, clear sequence and randomized
// reference-model checks for regs_port_ctrl.
module tb_regs_port_ctrl;

  localparam int D = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        io_valid;
  logic        io_ready;
  logic [4:0]  io_reg;
  logic [31:0] io_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic        stall;
  logic        wb_drop;
  logic [1:0]  io_count;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  regs_port_ctrl #(.IO_DEPTH(D), .NUM_REGS(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_write   (wb_write),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .io_reg     (io_reg),
    .io_data    (io_data),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .stall      (stall),
    .wb_drop    (wb_drop),
    .io_count   (io_count),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  typedef struct {
    logic        rst;
    logic        wbw;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        iov;
    logic [4:0]  ior;
    logic [31:0] iod;
    logic        ew;
    logic [4:0]  er;
    logic [31:0] ed;
    logic        erdy;
    logic [1:0]  ecnt;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  vec_t tbl [18];

  function automatic vec_t mk(
    int rst, int wbw, int wbr, int wbd,
    int iov, int ior, int iod,
    int ew, int er, int ed, int rdy, int cnt);
    vec_t v;
    v.rst = 1'(rst);  v.wbw = 1'(wbw);
    v.wbr = 5'(wbr);  v.wbd = 32'(wbd);
    v.iov = 1'(iov);  v.ior = 5'(ior);
    v.iod = 32'(iod); v.ew = 1'(ew);
    v.er = 5'(er);    v.ed = 32'(ed);
    v.erdy = 1'(rdy); v.ecnt = 2'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic drive(
    input logic rst, input logic wbw,
    input logic [4:0] wbr, input logic [31:0] wbd,
    input logic iov, input logic [4:0] ior,
    input logic [31:0] iod, input logic clr);
    @(negedge clock);
    reset = rst;   wb_write = wbw;
    wb_reg = wbr;  wb_data = wbd;
    io_valid = iov; io_reg = ior;
    io_data = iod; clr_req = clr;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // reference model state
  bit   m_busy;
  int   m_left;
  bit   m_drop;
  ent_t q [$];

  initial begin
    tbl[0]  = mk(1,0,0,0,      0,0,0,      0,0,0,1,0);
    tbl[1]  = mk(0,0,0,0,      1,25,'hA5,  0,0,0,1,0);
    tbl[2]  = mk(0,0,0,0,      0,0,0,      1,25,'hA5,1,1);
    tbl[3]  = mk(0,0,0,0,      0,0,0,      0,0,0,1,0);
    tbl[4]  = mk(0,1,8,'h11,   1,9,'h99,   1,8,'h11,1,0);
    tbl[5]  = mk(0,1,8,'h22,   0,0,0,      1,8,'h22,1,1);
    tbl[6]  = mk(0,1,8,'h33,   0,0,0,      1,8,'h33,1,1);
    tbl[7]  = mk(0,0,0,0,      0,0,0,      1,9,'h99,1,1);
    tbl[8]  = mk(0,0,0,0,      0,0,0,      0,0,0,1,0);
    tbl[9]  = mk(0,1,8,'h44,   1,10,'hA0,  1,8,'h44,1,0);
    tbl[10] = mk(0,1,8,'h45,   1,11,'hB0,  1,8,'h45,1,1);
    tbl[11] = mk(0,1,8,'h46,   1,12,'hC0,  1,8,'h46,0,2);
    tbl[12] = mk(0,0,0,0,      0,0,0,      1,10,'hA0,0,2);
    tbl[13] = mk(0,0,0,0,      0,0,0,      1,11,'hB0,1,1);
    tbl[14] = mk(0,0,0,0,      0,0,0,      0,0,0,1,0);
    tbl[15] = mk(0,1,0,'hDEAD, 1,0,'h55,   0,0,0,1,0);
    tbl[16] = mk(0,0,0,0,      0,0,0,      0,0,0,1,1);
    tbl[17] = mk(0,0,0,0,      0,0,0,      0,0,0,1,0);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", io_ready, 1);
    chk("rst_count", io_count, 0);
    chk("rst_stall", stall, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_drop", wb_drop, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wbw, tbl[i].wbr,
            tbl[i].wbd, tbl[i].iov, tbl[i].ior,
            tbl[i].iod, 1'b0);
      chk($sformatf("tbl%0d_write", i),
          write, tbl[i].ew);
      if (tbl[i].ew) begin
        chk($sformatf("tbl%0d_reg", i),
            write_reg, tbl[i].er);
        chk($sformatf("tbl%0d_data", i),
            write_data, tbl[i].ed);
      end
      chk($sformatf("tbl%0d_ready", i),
          io_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d_count", i),
          io_count, tbl[i].ecnt);
      chk($sformatf("tbl%0d_stall", i), stall, 0);
    end

    // clear sequence with a dropped WB write and a
    // queued I/O write that must land afterwards
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_pre_stall", stall, 0);
    for (int k = 0; k < 32; k++) begin
      drive(0, k == 4, 4, 32'h1234, k == 10, 7,
            32'h77, 1'b0);
      chk($sformatf("clr%0d_stall", k), stall, 1);
      chk($sformatf("clr%0d_write", k), write, 1);
      chk($sformatf("clr%0d_reg", k), write_reg, k);
      chk($sformatf("clr%0d_data", k), write_data, 0);
      chk($sformatf("clr%0d_done", k), clr_done,
          k == 31);
      if (k == 10) chk("clr_io_ready", io_ready, 1);
      if (k == 5) chk("clr_drop_set", wb_drop, 1);
    end
    idle();
    chk("post_clr_stall", stall, 0);
    chk("post_clr_write", write, 1);
    chk("post_clr_reg", write_reg, 7);
    chk("post_clr_data", write_data, 32'h77);
    chk("post_clr_drop", wb_drop, 1);
    idle();
    chk("post_clr_idle", write, 0);
    chk("drop_sticky", wb_drop, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("drop_cleared", wb_drop, 0);

    // randomized run against the reference model
    m_busy = 0; m_left = 0; m_drop = 0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        rst, wbw, iov, clr;
      logic [4:0]  wbr, ior;
      logic [31:0] wbd, iod;
      logic        ew, acc;
      logic [4:0]  er;
      logic [31:0] ed;
      rst = (c == 0) || ($urandom_range(0, 299) == 0);
      wbw = ($urandom_range(0, 9) < 4);
      wbr = ($urandom_range(0, 5) == 0) ? 5'd0
                                        : 5'($urandom);
      wbd = $urandom;
      iov = ($urandom_range(0, 1) == 1);
      ior = ($urandom_range(0, 5) == 0) ? 5'd0
                                        : 5'($urandom);
      iod = $urandom;
      clr = ($urandom_range(0, 59) == 0);
      drive(rst, wbw, wbr, wbd, iov, ior, iod, clr);

      ew = 0; er = 0; ed = 0;
      if (m_busy) begin
        ew = 1;
        er = 5'(32 - m_left);
        ed = 0;
      end else if (wbw && wbr != 0) begin
        ew = 1; er = wbr; ed = wbd;
      end else if (q.size() > 0 && q[0].r != 0) begin
        ew = 1; er = q[0].r; ed = q[0].d;
      end
      chk("rnd_write", write, ew);
      if (ew) begin
        chk("rnd_reg", write_reg, er);
        chk("rnd_data", write_data, ed);
      end
      chk("rnd_ready", io_ready, q.size() < D);
      chk("rnd_count", io_count, q.size());
      chk("rnd_stall", stall, m_busy);
      chk("rnd_busy", clr_busy, m_busy);
      chk("rnd_done", clr_done,
          m_busy && m_left == 1);
      chk("rnd_drop", wb_drop, m_drop);

      acc = iov && (q.size() < D);
      if (rst) begin
        m_busy = 0; m_left = 0; m_drop = 0;
        q.delete();
      end else begin
        if (m_busy) begin
          if (wbw) m_drop = 1;
          m_left--;
          if (m_left == 0) m_busy = 0;
        end else begin
          if (!(wbw && wbr != 0) && q.size() > 0)
            void'(q.pop_front());
          if (clr) begin
            m_busy = 1;
            m_left = 32;
          end
        end
        if (acc) q.push_back('{r: ior, d: iod});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regs_port_ctrl.md
# regs_port_ctrl

Write-port controller for the 32×32 general register file. It shares the register file's single write port between the pipeline write-back stage and an external I/O requester. It also runs a register-clear sequence on request, stalling the pipeline while the sequence is active. It sits between the WB stage / I/O bridge and the register file's `write`, `write_reg` and `write_data` inputs.

## Interface
Parameters:
- `IO_DEPTH`, default 2: I/O write FIFO depth; power of two, ≥2.
- `NUM_REGS`, default 32: register count; fixed at 32.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `wb_write`  in  1  WB stage write request.
- `wb_reg`  in  5  WB destination register.
- `wb_data`  in  32  WB write data.
- `io_valid`  in  1  I/O write offered.
- `io_ready`  out  1  I/O write accepted when `io_valid & io_ready`.
- `io_reg`  in  5  I/O destination register.
- `io_data`  in  32  I/O write data.
- `clr_req`  in  1  start clear sequence (level; sampled in IDLE).
- `clr_busy`  out  1  clear sequence active.
- `clr_done`  out  1  one-cycle pulse on the final clear write.
- `stall`  out  1  pipeline must hold; equals `clr_busy`.
- `wb_drop`  out  1  sticky error: a WB write arrived during CLEAR.
- `io_count`  out  $clog2(IO_DEPTH)+1  FIFO occupancy.
- `write`  out  1  register-file write enable.
- `write_reg`  out  5  register-file write address.
- `write_data`  out  32  register-file write data.

## Operation
- FSM states: IDLE, CLEAR.
- IDLE → CLEAR when `clr_req`=1; `clr_cnt` loads 0.
- CLEAR → IDLE after the write with `clr_cnt`=31.
- In CLEAR, one write is issued per cycle: `write`=1, `write_reg`=`clr_cnt`, `write_data`=0. `clr_cnt` then increments.
- The full clear takes 32 cycles. `clr_done`=1 in the cycle where `clr_cnt`=31.
- `clr_req` is ignored while in CLEAR.
- IDLE write-port priority:
  1. WB write: when `wb_write`=1 and `wb_reg`≠0, pass WB through unchanged.
  2. FIFO head: when the FIFO is non-empty and the head register ≠0, write the head and pop it.
  3. Otherwise `write`=0.
- Writes to register 0 are never issued.
  - WB writes to register 0 are discarded.
  - A FIFO head targeting register 0 is popped without a write, taking one cycle.
- A FIFO head blocked by WB stays in place. There is no starvation bound; the WB stage owns the port.
- In CLEAR the FIFO neither drains nor is flushed. Queued entries are written after the clear completes, so they land on top of zeros.
- `io_ready` = FIFO not full, computed from the registered count. A push and a pop in the same cycle are legal when the FIFO is not full.
- `wb_write`=1 during CLEAR: the write is dropped and `wb_drop` sets to 1. `wb_drop` clears only on `reset`.
- Write-port outputs are combinational from the FSM state, FIFO head and WB inputs. A WB write therefore adds zero latency.

## Timing
- Reset values: state=IDLE, `clr_cnt`=0, FIFO empty, `io_count`=0, `io_ready`=1, `clr_busy`=0, `stall`=0, `clr_done`=0, `wb_drop`=0.
- With no WB write during reset, `write`=0.
- WB write: reaches the register file in the same cycle, and is committed at that cycle's clock edge.
- I/O write accepted in cycle N:
  - earliest commit is at the edge ending cycle N+1;
  - each cycle with a WB write delays it by one cycle.
- `clr_req` sampled high in IDLE at the edge ending cycle N:
  - `stall`=1 in cycles N+1 through N+32;
  - register k is written at the edge ending cycle N+1+k;
  - `stall`=0 in cycle N+33.
- A held-high `clr_req` re-enters CLEAR in cycle N+33, producing back-to-back sequences.
- `reset` during CLEAR aborts the sequence at the next edge and empties the FIFO. Registers not yet cleared keep their values; the register file's own reset clears them.

## Structure
- Shared package `regs_ctrl_pkg` contains:
  - FSM state enum;
  - `REG_ZERO`=5'd0;
  - `NUM_REGS`=32;
  - `REG_AW`=5.
- One sub-module, `regs_io_fifo`: synchronous FIFO holding {reg[4:0], data[31:0]}, with `IO_DEPTH` entries, full/empty flags and count.
- The FSM, `clr_cnt` and the priority mux live in the top module.

## Test plan
- Reset, then an I/O write of reg 25 = 0x0000_00A5 with WB idle → `write`=1, `write_reg`=25, `write_data`=0xA5 one cycle after acceptance; `io_count` returns to 0.
- WB writes reg 8 for 3 consecutive cycles while an I/O write to reg 9 is queued → three WB writes, then reg 9 written in the 4th cycle.
- Fill the FIFO with 2 entries while WB is busy every cycle → `io_ready`=0; both entries drain in FIFO order once WB goes idle.
- Pulse `clr_req` → `stall`=1 for exactly 32 cycles; `write_reg` sequences 0..31 with data 0; `clr_done` pulses with `write_reg`=31.
- `wb_write`=1 to reg 4 in the 5th CLEAR cycle → no WB write issued, `wb_drop`=1 until reset.
- I/O and WB writes to reg 0 → `write` stays 0; the FIFO entry pops in one cycle.
